// File: rtl/pp_pipeline_accel_hls_dl_pkg.sv
// Shared types and default sizing for the HLS pipeline deadlock monitor.
package pp_pipeline_accel_hls_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_CONF = 2'd2
  } dl_state_e;

  localparam int DL_PROC_NUM_DEF       = 4;
  localparam int DL_PROC_ID_DEF        = 0;
  localparam int DL_IN_CHAN_NUM_DEF    = 2;
  localparam int DL_OUT_CHAN_NUM_DEF   = 3;
  localparam int DL_CONFIRM_CYCLES_DEF = 16;
  localparam int DL_EVT_W_DEF          = 8;

endpackage

// File: rtl/pp_pipeline_accel_hls_dl_dep_merge.sv
// Merges the dependency sets of all incoming channels whose dependency valid is set.
module pp_pipeline_accel_hls_dl_dep_merge #(
  parameter int PROC_NUM    = 4,
  parameter int IN_CHAN_NUM = 2
) (
  input  logic [IN_CHAN_NUM-1:0]          i_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] i_chan_dep_data_vec,
  output logic [PROC_NUM-1:0]             o_merged
);

  always_comb begin
    o_merged = '0;
    for (int i = 0; i < IN_CHAN_NUM; i++) begin
      if (i_chan_dep_vld_vec[i]) begin
        o_merged = o_merged | i_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM];
      end
    end
  end

endmodule

// File: rtl/pp_pipeline_accel_hls_deadlock_monitor.sv
// Per-process deadlock monitor: propagates dependency sets and tokens, and confirms a
// deadlock once this process has depended on itself for CONFIRM_CYCLES consecutive cycles.
module pp_pipeline_accel_hls_deadlock_monitor
  import pp_pipeline_accel_hls_dl_pkg::*;
#(
  parameter int PROC_NUM       = DL_PROC_NUM_DEF,
  parameter int PROC_ID        = DL_PROC_ID_DEF,
  parameter int IN_CHAN_NUM    = DL_IN_CHAN_NUM_DEF,
  parameter int OUT_CHAN_NUM   = DL_OUT_CHAN_NUM_DEF,
  parameter int CONFIRM_CYCLES = DL_CONFIRM_CYCLES_DEF,
  parameter int EVT_W          = DL_EVT_W_DEF
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
  input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
  input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
  input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
  input  logic                            dl_detect_in,
  input  logic                            origin,
  input  logic                            token_clear,
  input  logic                            report_clear,
  output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
  output logic [PROC_NUM-1:0]             out_chan_dep_data,
  output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
  output logic                            dl_detect_out,
  output logic                            dl_candidate,
  output logic [PROC_NUM-1:0]             dl_snapshot,
  output logic [EVT_W-1:0]                dl_event_cnt
);

  localparam int                CNT_W    = $clog2(CONFIRM_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DONE = CNT_W'(CONFIRM_CYCLES);
  localparam logic [PROC_NUM-1:0] SELF_BIT = PROC_NUM'(1) << PROC_ID;
  localparam logic [EVT_W-1:0]  EVT_MAX  = '1;

  logic [PROC_NUM-1:0]     w_merged;
  logic                    w_open;
  logic                    w_blocked;
  logic [PROC_NUM-1:0]     w_dep;
  logic                    w_raw;
  logic                    w_tok_en;
  logic [CNT_W-1:0]        w_cnt_inc;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic                    w_confirm;
  dl_state_e               w_state_nxt;

  dl_state_e               r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [PROC_NUM-1:0]     r_dep;
  logic [OUT_CHAN_NUM-1:0] r_token_out;
  logic [PROC_NUM-1:0]     r_snapshot;
  logic [EVT_W-1:0]        r_evt_cnt;
  logic                    r_dl_detect;
  logic                    r_dl_cand;

  pp_pipeline_accel_hls_dl_dep_merge #(
    .PROC_NUM    (PROC_NUM),
    .IN_CHAN_NUM (IN_CHAN_NUM)
  ) u_dep_merge (
    .i_chan_dep_vld_vec  (in_chan_dep_vld_vec),
    .i_chan_dep_data_vec (in_chan_dep_data_vec),
    .o_merged            (w_merged)
  );

  // While a detection is circulating without a token, the dependency set is frozen.
  assign w_open    = ~dl_detect_in | (|token_in_vec);
  assign w_blocked = |proc_dep_vld_vec;
  assign w_dep     = w_open ? w_merged : r_dep;
  assign w_raw     = w_open & w_dep[PROC_ID] & w_blocked;
  assign w_tok_en  = ((|token_in_vec) & ~token_clear) | origin;
  assign w_cnt_inc = r_cnt + CNT_ONE;

  assign out_chan_dep_vld_vec = proc_dep_vld_vec;
  assign out_chan_dep_data    = r_dep | SELF_BIT;
  assign token_out_vec        = r_token_out;
  assign dl_detect_out        = r_dl_detect;
  assign dl_candidate         = r_dl_cand;
  assign dl_snapshot          = r_snapshot;
  assign dl_event_cnt         = r_evt_cnt;

  // A report_clear arriving on the confirming edge wins and drops back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_confirm   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_raw) begin
          if (CONFIRM_CYCLES == 1) begin
            if (!report_clear) begin
              w_state_nxt = ST_CONF;
              w_cnt_nxt   = CNT_ONE;
              w_confirm   = 1'b1;
            end
          end else begin
            w_state_nxt = ST_CAND;
            w_cnt_nxt   = CNT_ONE;
          end
        end
      end
      ST_CAND: begin
        if (!w_raw) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_inc == CNT_DONE) begin
          if (report_clear) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_CONF;
            w_cnt_nxt   = w_cnt_inc;
            w_confirm   = 1'b1;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      ST_CONF: begin
        if (report_clear) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_dep       <= '0;
      r_token_out <= '0;
      r_snapshot  <= '0;
      r_evt_cnt   <= '0;
      r_dl_detect <= 1'b0;
      r_dl_cand   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_dep       <= w_blocked ? w_dep : '0;
      r_token_out <= w_tok_en ? proc_dep_vld_vec : '0;
      r_dl_detect <= (w_state_nxt == ST_CONF);
      r_dl_cand   <= (w_state_nxt == ST_CAND);
      if (w_confirm) begin
        r_snapshot <= w_dep;
        if (r_evt_cnt != EVT_MAX) begin
          r_evt_cnt <= r_evt_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pp_pipeline_accel_hls_deadlock_monitor.sv
// Randomised and directed bench for the deadlock monitor against a streak-counting reference model.
module tb_pp_pipeline_accel_hls_deadlock_monitor;

  localparam int CONFIRM = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] pv    = '0;
  logic [1:0] vld   = '0;
  logic [7:0] data  = '0;
  logic [1:0] tok   = '0;
  logic       dli   = 1'b0;
  logic       orig  = 1'b0;
  logic       tclr  = 1'b0;
  logic       rclr  = 1'b0;

  logic [2:0] outVld;
  logic [3:0] outData;
  logic [2:0] tokOut;
  logic       detect;
  logic       cand;
  logic [3:0] snap;
  logic [7:0] evt;

  int checks = 0;
  int errors = 0;

  // Reference model: dependency register, length of the current self-dependency streak,
  // whether a report is pending, and the report bookkeeping.
  logic [3:0] mDepReg   = '0;
  int         mStreak   = 0;
  bit         mReported = 1'b0;
  logic [3:0] mSnap     = '0;
  int         mEvents   = 0;
  logic [2:0] mTok      = '0;

  pp_pipeline_accel_hls_deadlock_monitor #(
    .PROC_NUM       (4),
    .PROC_ID        (1),
    .IN_CHAN_NUM    (2),
    .OUT_CHAN_NUM   (3),
    .CONFIRM_CYCLES (CONFIRM),
    .EVT_W          (8)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .proc_dep_vld_vec     (pv),
    .in_chan_dep_vld_vec  (vld),
    .in_chan_dep_data_vec (data),
    .token_in_vec         (tok),
    .dl_detect_in         (dli),
    .origin               (orig),
    .token_clear          (tclr),
    .report_clear         (rclr),
    .out_chan_dep_vld_vec (outVld),
    .out_chan_dep_data    (outData),
    .token_out_vec        (tokOut),
    .dl_detect_out        (detect),
    .dl_candidate         (cand),
    .dl_snapshot          (snap),
    .dl_event_cnt         (evt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [3:0] modelDep();
    logic [3:0] merged;
    merged = (vld[0] ? data[3:0] : 4'h0) | (vld[1] ? data[7:4] : 4'h0);
    if (!dli || (tok != 2'b00)) return merged;
    return mDepReg;
  endfunction

  function automatic bit modelRaw();
    logic [3:0] dep;
    bit isOpen;
    dep    = modelDep();
    isOpen = !dli || (tok != 2'b00);
    return isOpen && dep[1] && (pv != 3'b000);
  endfunction

  task automatic modelReset();
    mDepReg   = '0;
    mStreak   = 0;
    mReported = 1'b0;
    mSnap     = '0;
    mEvents   = 0;
    mTok      = '0;
  endtask

  task automatic modelEdge();
    logic [3:0] dep;
    bit raw;
    dep = modelDep();
    raw = modelRaw();
    if (mReported) begin
      if (rclr) begin
        mReported = 1'b0;
        mStreak   = 0;
      end
    end else if (raw) begin
      mStreak++;
      if (mStreak >= CONFIRM) begin
        if (rclr) begin
          mStreak = 0;
        end else begin
          mReported = 1'b1;
          mSnap     = dep;
          if (mEvents < 255) mEvents++;
        end
      end
    end else begin
      mStreak = 0;
    end
    mTok    = (((tok != 2'b00) && !tclr) || orig) ? pv : 3'b000;
    mDepReg = (pv != 3'b000) ? dep : 4'h0;
  endtask

  task automatic checkAll();
    checkOutput("detect",    32'(detect),  32'(mReported));
    checkOutput("candidate", 32'(cand),    32'(!mReported && (mStreak > 0)));
    checkOutput("snapshot",  32'(snap),    32'(mSnap));
    checkOutput("events",    32'(evt),     32'(mEvents));
    checkOutput("tokenOut",  32'(tokOut),  32'(mTok));
    checkOutput("depOut",    32'(outData), 32'(mDepReg | 4'b0010));
    checkOutput("vldOut",    32'(outVld),  32'(pv));
  endtask

  task automatic applyStimulus(input logic [2:0] iPv, input logic [1:0] iVld, input logic [7:0] iData,
                               input logic iDli, input logic [1:0] iTok, input logic iOrig,
                               input logic iTclr, input logic iRclr);
    pv = iPv; vld = iVld; data = iData; dli = iDli;
    tok = iTok; orig = iOrig; tclr = iTclr; rclr = iRclr;
    @(posedge clock);
    modelEdge();
    #1;
    checkAll();
  endtask

  task automatic asyncReset();
    #2;
    reset = 1'b0;
    #1;
    modelReset();
    checkAll();
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic rawCycle(input logic iRclr);
    applyStimulus(3'b001, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0, iRclr);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    checkAll();
    @(negedge clock);
    reset = 1'b1;

    // Four raw cycles confirm, candidate visible for the first three.
    repeat (4) rawCycle(1'b0);
    checkOutput("req030_detect", 32'(detect), 32'd1);
    checkOutput("req030_snap",   32'(snap),   32'h2);
    checkOutput("req030_evt",    32'(evt),    32'd1);

    // Clear while raw persists, then reconfirm after four more cycles.
    rawCycle(1'b1);
    checkOutput("req032_cleared", 32'(detect), 32'd0);
    repeat (4) rawCycle(1'b0);
    checkOutput("req032_detect", 32'(detect), 32'd1);
    checkOutput("req032_evt",    32'(evt),    32'd2);
    applyStimulus(3'b000, 2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // A one-cycle gap restarts the streak.
    repeat (3) rawCycle(1'b0);
    applyStimulus(3'b000, 2'b01, 8'h02, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    repeat (3) rawCycle(1'b0);
    checkOutput("req031_nodetect", 32'(detect), 32'd0);
    rawCycle(1'b0);
    checkOutput("req031_detect", 32'(detect), 32'd1);
    applyStimulus(3'b000, 2'b00, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);

    // Dependency set frozen without a token, following merged once a token arrives.
    applyStimulus(3'b001, 2'b01, 8'h08, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 2'b01, 8'h04, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b001, 2'b11, 8'h51, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
    checkOutput("req033_frozen", 32'(outData), 32'hA);
    applyStimulus(3'b001, 2'b01, 8'h04, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
    checkOutput("req033_follow", 32'(outData), 32'h6);

    // Token forwarding from an origin, then suppression by token_clear.
    applyStimulus(3'b101, 2'b00, 8'h00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("req034_token", 32'(tokOut), 32'h5);
    applyStimulus(3'b101, 2'b00, 8'h00, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);
    checkOutput("req034_clear", 32'(tokOut), 32'h0);

    // Reset mid-candidate aborts; four fresh cycles are needed afterwards.
    repeat (3) applyStimulus(3'b001, 2'b01, 8'h02, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    checkOutput("req035_cand", 32'(cand), 32'd1);
    asyncReset();
    checkOutput("req035_rstCand", 32'(cand), 32'd0);
    repeat (3) rawCycle(1'b0);
    checkOutput("req035_notYet", 32'(detect), 32'd0);
    rawCycle(1'b0);
    checkOutput("req035_detect", 32'(detect), 32'd1);
    checkOutput("req035_evt",    32'(evt),    32'd1);

    // Drive the event counter into saturation.
    rawCycle(1'b1);
    for (int n = 0; n < 260; n++) begin
      repeat (4) rawCycle(1'b0);
      rawCycle(1'b1);
    end
    checkOutput("evtSaturated", 32'(evt), 32'd255);

    // Randomised traffic biased towards self-dependency.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] rPv;
      logic [1:0] rVld;
      logic [7:0] rData;
      logic [1:0] rTok;
      rPv   = ($urandom_range(0, 4) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      rVld  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0)};
      rData = 8'($urandom);
      if ($urandom_range(0, 9) < 8) rData[1] = 1'b1;
      rTok  = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom);
      applyStimulus(rPv, rVld, rData, $urandom_range(0, 3) == 0, rTok,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 5) == 0);
      if (i % 700 == 350) asyncReset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
